// File: rtl/tiny_rv_exec_ctrl.sv
`default_nettype none
// ============================================================================
// tiny_rv_exec_ctrl : execute-stage sequencer around the combinational ALU
// Rev 1.0
// ============================================================================
module tiny_rv_exec_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_rs1,
   input  logic [31:0]      in_rs2,
   input  logic [31:0]      in_imm,
   input  logic [6:0]       in_opcode,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [4:0]       in_rd,
   output logic [31:0]      alu_pc,
   output logic [31:0]      alu_rs1,
   output logic [31:0]      alu_rs2,
   output logic [31:0]      alu_imm,
   output logic [6:0]       alu_opcode,
   output logic [2:0]       alu_funct3,
   output logic [6:0]       alu_funct7,
   input  logic [31:0]      alu_result,
   input  logic             alu_active,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_rd,
   output logic [31:0]      out_result,
   output logic             out_we,
   output logic             out_illegal,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [4:0] op_rd;
   logic       accept;

   // DONE forwards writeback readiness so a new instruction can issue while the old one retires
   assign in_ready = !i_flush && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept   = in_valid && in_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         alu_pc      <= '0;
         alu_rs1     <= '0;
         alu_rs2     <= '0;
         alu_imm     <= '0;
         alu_opcode  <= '0;
         alu_funct3  <= '0;
         alu_funct7  <= '0;
         op_rd       <= '0;
         out_valid   <= 1'b0;
         out_rd      <= '0;
         out_result  <= '0;
         out_we      <= 1'b0;
         out_illegal <= 1'b0;
         out_count   <= '0;
      end else if (i_flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            alu_pc     <= in_pc;
            alu_rs1    <= in_rs1;
            alu_rs2    <= in_rs2;
            alu_imm    <= in_imm;
            alu_opcode <= in_opcode;
            alu_funct3 <= in_funct3;
            alu_funct7 <= in_funct7;
            op_rd      <= in_rd;
         end
         case (state)
            IDLE: begin
               if (accept) state <= EXEC;
            end
            EXEC: begin
               out_result  <= alu_active ? alu_result : 32'd0;
               out_illegal <= !alu_active;
               out_we      <= alu_active && (op_rd != 5'd0);
               out_rd      <= op_rd;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_count <= out_count + 1'b1;
                  state     <= accept ? EXEC : IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tiny_rv_exec_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tiny_rv_exec_ctrl : directed bench, 32-bit and 4-bit counter instances
// Rev 1.0
// ============================================================================
module tb_tiny_rv_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
   logic [6:0]  in_opcode, in_funct7;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;

   logic        a_in_ready, a_alu_active, a_out_valid, a_out_we, a_out_illegal;
   logic [31:0] a_alu_pc, a_alu_rs1, a_alu_rs2, a_alu_imm, a_alu_result, a_out_result;
   logic [6:0]  a_alu_opcode, a_alu_funct7;
   logic [2:0]  a_alu_funct3;
   logic [4:0]  a_out_rd;
   logic [31:0] a_out_count;

   logic        b_in_ready, b_alu_active, b_out_valid, b_out_we, b_out_illegal;
   logic [31:0] b_alu_pc, b_alu_rs1, b_alu_rs2, b_alu_imm, b_alu_result, b_out_result;
   logic [6:0]  b_alu_opcode, b_alu_funct7;
   logic [2:0]  b_alu_funct3;
   logic [4:0]  b_out_rd;
   logic [3:0]  b_out_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Reference ALU: LUI, ADDI, SRLI/SRAI; everything else unrecognised
   function automatic logic [32:0] alu_model(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [31:0] rs1, input logic [31:0] imm);
      logic [32:0] r;
      r = 33'd0;
      if (op == 7'b0110111) r = {1'b1, imm};
      else if (op == 7'b0010011 && f3 == 3'b000) r = {1'b1, rs1 + imm};
      else if (op == 7'b0010011 && f3 == 3'b101)
         r = imm[10] ? {1'b1, 32'($signed(rs1) >>> imm[4:0])} : {1'b1, rs1 >> imm[4:0]};
      return r;
   endfunction

   always_comb {a_alu_active, a_alu_result} = alu_model(a_alu_opcode, a_alu_funct3, a_alu_rs1, a_alu_imm);
   always_comb {b_alu_active, b_alu_result} = alu_model(b_alu_opcode, b_alu_funct3, b_alu_rs1, b_alu_imm);

   tiny_rv_exec_ctrl #(.CNT_W(32)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
      .alu_pc(a_alu_pc), .alu_rs1(a_alu_rs1), .alu_rs2(a_alu_rs2), .alu_imm(a_alu_imm),
      .alu_opcode(a_alu_opcode), .alu_funct3(a_alu_funct3), .alu_funct7(a_alu_funct7),
      .alu_result(a_alu_result), .alu_active(a_alu_active),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_rd(a_out_rd),
      .out_result(a_out_result), .out_we(a_out_we), .out_illegal(a_out_illegal),
      .out_count(a_out_count)
   );

   tiny_rv_exec_ctrl #(.CNT_W(4)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
      .alu_pc(b_alu_pc), .alu_rs1(b_alu_rs1), .alu_rs2(b_alu_rs2), .alu_imm(b_alu_imm),
      .alu_opcode(b_alu_opcode), .alu_funct3(b_alu_funct3), .alu_funct7(b_alu_funct7),
      .alu_result(b_alu_result), .alu_active(b_alu_active),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_rd(b_out_rd),
      .out_result(b_out_result), .out_we(b_out_we), .out_illegal(b_out_illegal),
      .out_count(b_out_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] rs1, input logic [31:0] imm, input logic [4:0] rd);
      in_valid  = 1'b1;
      in_opcode = op;
      in_funct3 = f3;
      in_funct7 = f7;
      in_rs1    = rs1;
      in_rs2    = rs1 ^ 32'h5A5A5A5A;
      in_imm    = imm;
      in_rd     = rd;
      in_pc     = in_pc + 32'd4;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_pc = 32'h1000; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0;

      // reset
      tick(); tick();
      check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
      check("rst_count", a_out_count, 32'd0);
      check("rst_alu_pc", a_alu_pc, 32'd0);
      check("rst_out_result", a_out_result, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);

      // LUI
      present(7'b0110111, 3'd0, 7'd0, 32'd0, 32'h12345000, 5'd5);
      tick(); in_valid = 1'b0;
      check("lui_exec_valid", {31'd0, a_out_valid}, 32'd0);
      check("lui_alu_imm", a_alu_imm, 32'h12345000);
      tick();
      check("lui_valid", {31'd0, a_out_valid}, 32'd1);
      check("lui_result", a_out_result, 32'h12345000);
      check("lui_we", {31'd0, a_out_we}, 32'd1);
      check("lui_illegal", {31'd0, a_out_illegal}, 32'd0);
      check("lui_rd", {27'd0, a_out_rd}, 32'd5);
      check("lui_count0", a_out_count, 32'd0);
      tick();
      check("lui_count1", a_out_count, 32'd1);
      check("lui_idle_valid", {31'd0, a_out_valid}, 32'd0);

      // ADDI then SRAI back-to-back
      present(7'b0010011, 3'b000, 7'd0, 32'd7, 32'hFFFFFFFF, 5'd1);
      tick();
      present(7'b0010011, 3'b101, 7'b0100000, 32'h80000000, 32'h00000404, 5'd2);
      #1;
      check("b2b_exec_in_ready", {31'd0, a_in_ready}, 32'd0);
      tick();
      check("addi_result", a_out_result, 32'd6);
      check("addi_valid", {31'd0, a_out_valid}, 32'd1);
      check("addi_done_in_ready", {31'd0, a_in_ready}, 32'd1);
      tick(); in_valid = 1'b0;
      check("b2b_count", a_out_count, 32'd2);
      check("b2b_gap_valid", {31'd0, a_out_valid}, 32'd0);
      check("srai_alu_rs1", a_alu_rs1, 32'h80000000);
      tick();
      check("srai_result", a_out_result, 32'hF8000000);
      check("srai_valid", {31'd0, a_out_valid}, 32'd1);
      tick();
      check("srai_count", a_out_count, 32'd3);

      // unrecognised opcode
      present(7'b0110011, 3'd0, 7'd0, 32'd9, 32'd9, 5'd3);
      tick(); in_valid = 1'b0; tick();
      check("ill_flag", {31'd0, a_out_illegal}, 32'd1);
      check("ill_we", {31'd0, a_out_we}, 32'd0);
      check("ill_result", a_out_result, 32'd0);
      tick();
      check("ill_count", a_out_count, 32'd4);

      // write to x0
      present(7'b0010011, 3'b000, 7'd0, 32'd10, 32'd5, 5'd0);
      tick(); in_valid = 1'b0; tick();
      check("x0_we", {31'd0, a_out_we}, 32'd0);
      check("x0_result", a_out_result, 32'd15);
      check("x0_illegal", {31'd0, a_out_illegal}, 32'd0);
      tick();
      check("x0_count", a_out_count, 32'd5);

      // writeback stall with a waiting instruction
      out_ready = 1'b0;
      present(7'b0010011, 3'b000, 7'd0, 32'd100, 32'd1, 5'd2);
      tick();
      present(7'b0010011, 3'b000, 7'd0, 32'd200, 32'd2, 5'd4);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", {31'd0, a_out_valid}, 32'd1);
         check("stall_result", a_out_result, 32'd101);
         check("stall_rd", {27'd0, a_out_rd}, 32'd2);
         check("stall_in_ready", {31'd0, a_in_ready}, 32'd0);
         check("stall_alu_rs1", a_alu_rs1, 32'd100);
         tick();
      end
      check("stall_count", a_out_count, 32'd5);
      out_ready = 1'b1;
      #1;
      check("release_in_ready", {31'd0, a_in_ready}, 32'd1);
      tick(); in_valid = 1'b0;
      check("release_count", a_out_count, 32'd6);
      check("release_alu_rs1", a_alu_rs1, 32'd200);
      tick();
      check("release_result", a_out_result, 32'd202);
      check("release_rd", {27'd0, a_out_rd}, 32'd4);
      tick();
      check("release_count2", a_out_count, 32'd7);

      // flush in EXEC
      present(7'b0010011, 3'b000, 7'd0, 32'd1, 32'd1, 5'd1);
      tick(); in_valid = 1'b0; flush = 1'b1;
      #1;
      check("flush_in_ready", {31'd0, a_in_ready}, 32'd0);
      tick(); flush = 1'b0;
      #1;
      check("flush_exec_valid", {31'd0, a_out_valid}, 32'd0);
      check("flush_exec_in_ready", {31'd0, a_in_ready}, 32'd1);
      check("flush_exec_count", a_out_count, 32'd7);
      check("flush_keeps_rs1", a_alu_rs1, 32'd1);
      tick();
      check("flush_exec_stays_idle", {31'd0, a_out_valid}, 32'd0);

      // flush in DONE with writeback ready
      present(7'b0010011, 3'b000, 7'd0, 32'd2, 32'd2, 5'd1);
      tick(); in_valid = 1'b0; tick();
      check("flush_done_valid_pre", {31'd0, a_out_valid}, 32'd1);
      flush = 1'b1;
      tick(); flush = 1'b0;
      #1;
      check("flush_done_valid", {31'd0, a_out_valid}, 32'd0);
      check("flush_done_count", a_out_count, 32'd7);
      check("flush_done_in_ready", {31'd0, a_in_ready}, 32'd1);

      // reset in DONE
      present(7'b0010011, 3'b000, 7'd0, 32'd3, 32'd4, 5'd9);
      tick(); in_valid = 1'b0; tick();
      out_ready = 1'b0; rst_n = 1'b0;
      tick();
      check("rst_done_valid", {31'd0, a_out_valid}, 32'd0);
      check("rst_done_result", a_out_result, 32'd0);
      check("rst_done_we", {31'd0, a_out_we}, 32'd0);
      check("rst_done_rd", {27'd0, a_out_rd}, 32'd0);
      check("rst_done_alu_rs1", a_alu_rs1, 32'd0);
      check("rst_done_alu_imm", a_alu_imm, 32'd0);
      check("rst_done_count", a_out_count, 32'd0);
      rst_n = 1'b1; out_ready = 1'b1;

      // counter wrap on the 4-bit instance
      for (int i = 0; i < 17; i++) begin
         present(7'b0010011, 3'b000, 7'd0, 32'(i), 32'd1, 5'd1);
         tick(); in_valid = 1'b0; tick();
         check("wrap_result", b_out_result, 32'(i + 1));
         tick();
         check("wrap_count4", {28'd0, b_out_count}, 32'((i + 1) % 16));
         check("wrap_count32", a_out_count, 32'(i + 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
